mc_control_fsm: RTL
===================

# mc_control_fsm

Multi-cycle control unit for the 16-bit, 8-register processor. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath control strobe, including `reg_write` into the register file, which sits directly downstream. Memory accesses wait on a ready handshake, so instruction latency stretches with memory wait states.

## Interface
Parameters:
- none; all encodings are fixed constants in `mc_pkg`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `opcode`  in  4  IR[15:12].
- `func`  in  3  IR[2:0]. Meaningful for R-type only.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero. The datapath ANDs this with zero.
- `pc_src`  out  2  PC source: 00 ALU result, 01 ALU-out register, 10 jump target.
- `i_or_d`  out  1  memory address: 0 PC, 1 ALU-out.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  load the instruction register.
- `reg_dst`  out  1  write register: 0 IR[8:6], 1 IR[5:3].
- `mem_to_reg`  out  1  write data: 0 ALU-out, 1 MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  ALU A input: 0 PC, 1 A latch.
- `alu_src_b`  out  2  ALU B input: 00 B latch, 01 constant 1, 10 sign-extended imm, 11 sign-extended imm (branch offset).
- `alu_op`  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- `state`  out  4  current state, for debug only.

## Operation
- Opcodes:
  - 0000 R-type; `func` 000–100 is legal, 101–111 is illegal.
  - 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J.
  - 0110–1111 illegal.
- Control outputs are Moore, decoded from `state`. Exceptions: `ir_write` and `pc_write` in FETCH are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00. Assert `ir_write` and `pc_write` when `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, add. Branch target goes to ALU-out. Next state by opcode:
    - R-type → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR; BEQ → BRANCH; J → JUMP.
    - Illegal opcode or illegal func → FETCH, with no architectural side effect.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=`func`. Next: WB_R.
  - WB_R: `reg_dst`=1, `mem_to_reg`=0, `reg_write`. Next: FETCH.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10, add. Next: WB_I.
  - WB_I: `reg_dst`=0, `mem_to_reg`=0, `reg_write`. Next: FETCH.
  - MEM_ADDR: same outputs as EXEC_I. Next: LW → MEM_RD, SW → MEM_WR.
  - MEM_RD: `mem_read`, `i_or_d`=1. Hold until `mem_ready`, then go to WB_MEM.
  - WB_MEM: `reg_dst`=0, `mem_to_reg`=1, `reg_write`. Next: FETCH.
  - MEM_WR: `mem_write`, `i_or_d`=1. Hold until `mem_ready`, then go to FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_write_cond`. Next: FETCH.
  - JUMP: `pc_src`=10, `pc_write`. Next: FETCH.
- Writes to r0 are issued normally. The register file discards them.

## Timing
- Reset:
  - While `rst`=0, every output is forced to 0 combinationally, including `state`.
  - On a clock edge with `rst`=0, `state` loads FETCH.
  - Reset asserted mid-instruction aborts that instruction. No `reg_write` or `mem_write` is asserted from the first reset cycle onward.
- Cycle counts with `mem_ready` high on the first request:
  - R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
  - Each low cycle of `mem_ready` in FETCH, MEM_RD or MEM_WR adds one cycle.
- While waiting, the request strobes and `i_or_d` stay stable.
- `mem_ready` sampled outside FETCH, MEM_RD and MEM_WR is ignored.
- `opcode` and `func` are sampled only in DECODE. The IR is stable then.
- Exactly one `reg_write` pulse per register-writing instruction, in its final cycle.

## Structure
- `mc_pkg` holds:
  - the state enum (4-bit);
  - opcode and func constants;
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- Top: state register plus next-state logic.
- One sub-module, `mc_ctrl_decode`: purely combinational state→control-vector mapping, including reset gating.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, with `mem_ready` toggling → all outputs 0. After release, the first cycle is FETCH with `mem_read`=1.
- R-type add (opcode 0000, func 000), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_R, FETCH. `reg_write`=1 only in cycle 4, with `reg_dst`=1.
- LW (0010) with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total. `mem_read`=1 and `i_or_d`=1 are held for 3 cycles, then WB_MEM asserts `mem_to_reg`=1.
- BEQ (0100), then J (0101) → 3 cycles each. BRANCH shows `pc_write_cond`=1, `alu_op`=001, `pc_src`=01. JUMP shows `pc_write`=1, `pc_src`=10.
- Illegal opcode 1010 and R-type func 111 → DECODE returns to FETCH. No `reg_write`, `mem_write` or `pc_write` after FETCH.
- `rst` dropped in MEM_WR while `mem_ready`=0 → `mem_write` is 0 in that cycle. `state` is FETCH after release.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// mc_pkg - shared encodings for the multi-cycle control unit (rev 1.0)
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [2:0] FUNC_MAX = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
  } ctrl_t;

  function automatic logic func_legal(input logic [2:0] f);
    return (f <= FUNC_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if - instruction/memory inputs and datapath strobes (rev 1.0)
`default_nettype none

interface mc_control_fsm_if;
  logic [3:0] opcode;
  logic [2:0] func;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  modport master (
    input  opcode, func, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, state
  );

  modport slave (
    output opcode, func, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm_decode.sv
// mc_ctrl_decode - combinational state to control-vector map with reset gating (rev 1.0)
`default_nettype none

module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [2:0] alu_func,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    // Reset low blanks every strobe, so an aborted write never reaches the datapath
    if (rst) begin
      ctrl.state = state;
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_src    = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_BOFF;
          ctrl.alu_op    = ALU_ADD;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = alu_func;
        end
        S_WB_R: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        S_WB_I: begin
          ctrl.reg_write = 1'b1;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_src        = PCSRC_ALUOUT;
          ctrl.pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_src   = PCSRC_JUMP;
          ctrl.pc_write = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// mc_control_fsm - multi-cycle instruction sequencer: state register and next-state logic (rev 1.0)
`default_nettype none

module mc_control_fsm
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  bus
);

  state_t     state_q;
  logic       is_store;
  logic [2:0] func_q;
  ctrl_t      ctrl;

  // opcode/func are only valid in DECODE, so the parts needed later are latched there
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      is_store <= 1'b0;
      func_q   <= 3'b000;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          func_q   <= bus.func;
          is_store <= (bus.opcode == OP_SW);
          case (bus.opcode)
            OP_RTYPE: state_q <= func_legal(bus.func) ? S_EXEC_R : S_FETCH;
            OP_ADDI:  state_q <= S_EXEC_I;
            OP_LW:    state_q <= S_MEM_ADDR;
            OP_SW:    state_q <= S_MEM_ADDR;
            OP_BEQ:   state_q <= S_BRANCH;
            OP_J:     state_q <= S_JUMP;
            default:  state_q <= S_FETCH;
          endcase
        end
        S_EXEC_R:   state_q <= S_WB_R;
        S_EXEC_I:   state_q <= S_WB_I;
        S_MEM_ADDR: state_q <= is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (bus.mem_ready) state_q <= S_WB_MEM;
        end
        S_MEM_WR: begin
          if (bus.mem_ready) state_q <= S_FETCH;
        end
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .rst       (rst),
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .alu_func  (func_q),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.state         = ctrl.state;

endmodule

`default_nettype wire
